mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle sequencer for the MIPS single-cycle datapath.
- Decodes opcode/funct and walks each instruction through FETCH/DECODE/EXEC/MEM/WB, driving the datapath mux/ALU controls.
- Gates PC and register-file updates to exactly one cycle per instruction.
- Handles ready-based handshakes with instruction and data memory, with timeout trap and retired-instruction counter.

Parameters:
- TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready before trap (≥1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- opcode  in  6  inst[31:26] from instruction memory.
- funct  in  6  inst[5:0].
- alu_zero  in  1  ALU zero flag from datapath.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  fetch request, held until imem_ready.
- ir_write  out  1  latch instruction word into IR.
- dmem_req  out  1  data access request, held until dmem_ready.
- dmem_we  out  1  write strobe, qualifies dmem_req (sw).
- pc_write  out  1  PC update enable.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  datapath control.
- alu_src  out  1  datapath control.
- mem_to_reg  out  1  datapath control.
- pc_src  out  1  datapath control.
- jump  out  1  datapath control.
- jal  out  1  datapath control.
- jr  out  1  datapath control.
- sll  out  1  datapath control.
- srl  out  1  datapath control.
- alusel  out  4  ALU operation.
- trap  out  1  sticky: illegal instruction or timeout.
- retired  out  CNT_W  instructions completed.

Behaviour:
- Reset (rst high at clk edge):
  - State = FETCH; wait counter = 0; retired = 0; trap = 0; decode register cleared.
  - All outputs 0, except imem_req = 1 in the first FETCH cycle after reset.
  - Reset mid-instruction aborts it with no pc_write/reg_write.
- FETCH:
  - imem_req = 1.
  - On imem_ready: ir_write = 1 (same cycle), go to DECODE.
  - Otherwise increment wait counter; reaching TIMEOUT → TRAP.
- DECODE:
  - Latch decoded controls into register; controls stay stable through WB.
  - Illegal opcode/funct → TRAP.
  - j/jal/jr/beq/bne → WB; all others → EXEC.
- EXEC:
  - One cycle; ALU settles.
  - lw/sw → MEM; else → WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for sw; held stable until dmem_ready.
  - dmem_ready → WB; timeout → TRAP.
  - dmem_ready in the same cycle the counter hits TIMEOUT: ready wins.
- WB (single cycle):
  - pc_write = 1.
  - reg_write = 1 for R-type except jr, addi, lw, jal.
  - retired += 1, wrapping modulo 2^CNT_W.
  - Next state FETCH.
- TRAP:
  - trap = 1; all enables and requests 0.
  - Held until rst.
- Wait counter clears on every state change.
- Latency with zero wait states:
  - 3 cycles for branch/jump.
  - 4 cycles for R-type/addi.
  - 5 cycles for lw/sw.
- Control-signal timing:
  - Mux/ALU controls (reg_dst, alu_src, mem_to_reg, jump, jal, jr, sll, srl, alusel) come from the decode register, valid from the cycle after DECODE through WB.
  - pc_src is combinational: (beq & alu_zero) | (bne & ~alu_zero). It matters only when pc_write is asserted.
- Decode table (opcode, funct → alusel):
  - R-type 0x00: add 0x20 → ADD; sub 0x22 → SUB; and 0x24 → AND; or 0x25 → OR; slt 0x2A → SLT; sll 0x00 → SLL (sll=1); srl 0x02 → SRL (srl=1); jr 0x08 → jr=1.
  - R-type reg_dst = 1.
  - addi 0x08 → ADD, alu_src = 1.
  - lw 0x23 → ADD, alu_src = 1, mem_to_reg = 1.
  - sw 0x2B → ADD, alu_src = 1.
  - beq 0x04 / bne 0x05 → SUB.
  - j 0x02 → jump = 1.
  - jal 0x03 → jump = 1, jal = 1.
- alusel codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001.

Decomposition:
- Package mc_ctrl_pkg:
  - State enum: FETCH, DECODE, EXEC, MEM, WB, TRAP.
  - Opcode and funct constants.
  - alusel constants.
  - Packed decode-control struct.
- Sub-module mc_decode: purely combinational opcode/funct → control struct plus illegal flag.
- mc_ctrl holds the FSM, wait counter, retired counter and decode register.

Test Plan:
- add (op 0x00, funct 0x20), ready always 1 → pc_write and reg_write high together in cycle 4 only; reg_dst = 1; alusel = 0010; retired = 1.
- lw (0x23), dmem_ready delayed 3 cycles → dmem_req held 4 cycles with dmem_we = 0; WB in cycle 8; mem_to_reg = 1; reg_write = 1.
- beq with alu_zero = 1 then 0 → cycle 3: pc_write = 1, pc_src = 1 then 0; reg_write = 0.
- Illegal instructions:
  - opcode 0x3F → trap = 1 after DECODE; no pc_write/reg_write ever after.
  - R-type funct 0x01 → same trap response.
- imem_ready stuck 0, TIMEOUT = 16 → TRAP entered after 16 FETCH cycles; dmem_ready coinciding with the limit → WB, not TRAP.
- rst asserted in MEM of sw → next cycle FETCH; dmem_req = 0; retired = 0; no pc_write.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// Opcode/funct values follow the MIPS32 instruction encoding.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       sll;
    logic       srl;
    logic [3:0] alusel;
  } ctrl_t;

  // Control-flow instructions resolve in WB without an EXEC cycle.
  function automatic logic skips_exec(ctrl_t c);
    return c.jump | c.jr | c.beq | c.bne;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder producing the datapath control bundle.
// Unknown encodings raise illegal; the bundle is then don't-care.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_wr  = 1'b1;
        case (funct)
          F_ADD: ctrl.alusel = ALU_ADD;
          F_SUB: ctrl.alusel = ALU_SUB;
          F_AND: ctrl.alusel = ALU_AND;
          F_OR:  ctrl.alusel = ALU_OR;
          F_SLT: ctrl.alusel = ALU_SLT;
          F_SLL: begin ctrl.alusel = ALU_SLL; ctrl.sll = 1'b1; end
          F_SRL: begin ctrl.alusel = ALU_SRL; ctrl.srl = 1'b1; end
          F_JR:  begin ctrl.alusel = ALU_ADD; ctrl.jr = 1'b1; ctrl.reg_wr = 1'b0; end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        ctrl.alusel  = ALU_ADD;
        ctrl.alu_src = 1'b1;
        ctrl.reg_wr  = 1'b1;
      end
      OP_LW: begin
        ctrl.alusel     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.mem_rd     = 1'b1;
        ctrl.reg_wr     = 1'b1;
      end
      OP_SW: begin
        ctrl.alusel  = ALU_ADD;
        ctrl.alu_src = 1'b1;
        ctrl.mem_wr  = 1'b1;
      end
      OP_BEQ: begin ctrl.alusel = ALU_SUB; ctrl.beq = 1'b1; end
      OP_BNE: begin ctrl.alusel = ALU_SUB; ctrl.bne = 1'b1; end
      OP_J:   ctrl.jump = 1'b1;
      OP_JAL: begin ctrl.jump = 1'b1; ctrl.jal = 1'b1; ctrl.reg_wr = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// wait-state timeout trap and retired-instruction counter.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             pc_src,
  output logic             jump,
  output logic             jal,
  output logic             jr,
  output logic             sll,
  output logic             srl,
  output logic [3:0]       alusel,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  ctrl_t              dec_q, dec_d;

  ctrl_t dec_ctrl;
  logic  dec_illegal;

  mc_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    dec_d     = dec_q;
    case (state_q)
      FETCH: begin
        if (imem_ready)             state_d = DECODE;
        else if (wait_q == TO_LAST) state_d = TRAP;
        else                        wait_d  = wait_q + WAIT_W'(1);
      end
      DECODE: begin
        if (dec_illegal) begin
          state_d = TRAP;
        end else begin
          dec_d   = dec_ctrl;
          state_d = skips_exec(dec_ctrl) ? WB : EXEC;
        end
      end
      EXEC:   state_d = (dec_q.mem_rd | dec_q.mem_wr) ? MEM : WB;
      // Ready is checked first so a completion on the last allowed cycle wins.
      MEM: begin
        if (dmem_ready)             state_d = WB;
        else if (wait_q == TO_LAST) state_d = TRAP;
        else                        wait_d  = wait_q + WAIT_W'(1);
      end
      WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      retired_q <= '0;
      dec_q     <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      dec_q     <= dec_d;
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign ir_write   = (state_q == FETCH) & imem_ready;
  assign dmem_req   = (state_q == MEM);
  assign dmem_we    = (state_q == MEM) & dec_q.mem_wr;
  assign pc_write   = (state_q == WB);
  assign reg_write  = (state_q == WB) & dec_q.reg_wr;
  assign trap       = (state_q == TRAP);
  assign retired    = retired_q;

  assign reg_dst    = dec_q.reg_dst;
  assign alu_src    = dec_q.alu_src;
  assign mem_to_reg = dec_q.mem_to_reg;
  assign jump       = dec_q.jump;
  assign jal        = dec_q.jal;
  assign jr         = dec_q.jr;
  assign sll        = dec_q.sll;
  assign srl        = dec_q.srl;
  assign alusel     = dec_q.alusel;
  assign pc_src     = (dec_q.beq & alu_zero) | (dec_q.bne & ~alu_zero);

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus queues expected retire/trap events,
// a negedge monitor pops and compares whenever pc_write or a new trap appears.
module tb_mc_ctrl;

  logic        clk, rst;
  logic [5:0]  opcode, funct;
  logic        alu_zero, imem_ready, dmem_ready;
  logic        imem_req, ir_write, dmem_req, dmem_we, pc_write, reg_write;
  logic        reg_dst, alu_src, mem_to_reg, pc_src, jump, jal, jr, sll, srl;
  logic [3:0]  alusel;
  logic        trap;
  logic [31:0] retired;

  mc_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .pc_src(pc_src), .jump(jump),
    .jal(jal), .jr(jr), .sll(sll), .srl(srl), .alusel(alusel), .trap(trap),
    .retired(retired)
  );

  typedef struct {
    bit         is_trap;
    int         lat;
    logic [9:0] ctrl;   // {reg_write,reg_dst,alu_src,mem_to_reg,pc_src,jump,jal,jr,sll,srl}
    logic [3:0] alu;
    bit         alu_dc;
    int         dreq;
    bit         we;
    int         ret;
    int         start;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, events = 0, exp_ret = 0;
  int   imem_lat = 0, dmem_lat = 0;
  int   n_dreq = 0, n_stray_rw = 0, n_bad = 0;
  bit   saw_we = 0, trap_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t ex(int lat, logic [9:0] ctrl, logic [3:0] alu, bit dc, int dreq, bit we);
    exp_t e;
    e = '{default: 0};
    e.lat = lat; e.ctrl = ctrl; e.alu = alu; e.alu_dc = dc; e.dreq = dreq; e.we = we;
    return e;
  endfunction

  function automatic exp_t tx(int lat);
    exp_t e;
    e = '{default: 0};
    e.is_trap = 1; e.lat = lat;
    return e;
  endfunction

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // Memory responder: ready after a programmed number of request cycles.
  initial begin
    int iw, dw;
    iw = 0; dw = 0; imem_ready = 0; dmem_ready = 0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        iw = 0; dw = 0; imem_ready = 0; dmem_ready = 0;
      end else begin
        imem_ready = imem_req && (iw >= imem_lat);
        iw = imem_req ? iw + 1 : 0;
        dmem_ready = dmem_req && (dw >= dmem_lat);
        dw = dmem_req ? dw + 1 : 0;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        trap_seen = 0; n_dreq = 0; saw_we = 0; n_stray_rw = 0; n_bad = 0;
      end else begin
        if (dmem_req) n_dreq++;
        if (dmem_req && dmem_we) saw_we = 1;
        if (reg_write && !pc_write) n_stray_rw++;
        if (trap && (pc_write || reg_write || imem_req || dmem_req)) n_bad++;
        if (pc_write || (trap && !trap_seen)) begin
          if (sb.size() == 0) begin
            chk("unexpected_event", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("event_kind_trap", trap, e.is_trap);
            chk("latency", cyc - e.start + 1, e.lat);
            if (!e.is_trap) begin
              chk("ctrl", {reg_write, reg_dst, alu_src, mem_to_reg, pc_src, jump, jal, jr, sll, srl}, e.ctrl);
              if (!e.alu_dc) chk("alusel", alusel, e.alu);
              chk("dmem_req_cycles", n_dreq, e.dreq);
              chk("dmem_we", saw_we, e.we);
              chk("stray_reg_write", n_stray_rw, 0);
              chk("retired", retired, e.ret);
            end
          end
          if (trap) trap_seen = 1;
          n_dreq = 0; saw_we = 0; n_stray_rw = 0;
          events++;
        end
      end
    end
  end

  // Caller is at posedge+#1 of the FETCH cycle; returns at posedge+#1 after the event.
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input bit az,
                     input int il, input int dl, input exp_t e);
    int ev0;
    opcode = op; funct = fn; alu_zero = az; imem_lat = il; dmem_lat = dl;
    e.start = cyc; e.ret = exp_ret;
    if (!e.is_trap) exp_ret++;
    sb.push_back(e);
    ev0 = events;
    for (int i = 0; i < 200 && events == ev0; i++) @(posedge clk);
    #1;
    chk("event_seen", int'(events != ev0), 1);
  endtask

  task automatic do_reset();
    rst = 1; opcode = 0; funct = 0; alu_zero = 0; imem_lat = 0; dmem_lat = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_ret = 0;
  endtask

  task automatic trap_hold_check();
    repeat (6) @(posedge clk);
    #1;
    chk("trap_sticky", trap, 1);
    chk("trap_quiet", n_bad, 0);
    chk("trap_retired", retired, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1; opcode = 0; funct = 0; alu_zero = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_imem_req", imem_req, 1);
    chk("rst_outs", {dmem_req, dmem_we, pc_write, reg_write, trap, reg_dst, alu_src, mem_to_reg, pc_src, jump, jal, jr, sll, srl}, 0);
    chk("rst_alusel", alusel, 0);
    chk("rst_retired", retired, 0);
    @(posedge clk); #1 rst = 0;

    //      op     fn    az il dl          lat ctrl           alu    dc dreq we
    run(6'h00, 6'h20, 0, 0, 0,  ex(4,  10'b1100000000, 4'b0010, 0, 0, 0)); // add
    chk("retired_after_add", retired, 1);
    run(6'h23, 6'h00, 0, 0, 3,  ex(8,  10'b1011000000, 4'b0010, 0, 4, 0)); // lw, 3 wait
    run(6'h04, 6'h00, 1, 0, 0,  ex(3,  10'b0000100000, 4'b0110, 0, 0, 0)); // beq taken
    run(6'h04, 6'h00, 0, 0, 0,  ex(3,  10'b0000000000, 4'b0110, 0, 0, 0)); // beq not
    run(6'h05, 6'h00, 0, 0, 0,  ex(3,  10'b0000100000, 4'b0110, 0, 0, 0)); // bne taken
    run(6'h2B, 6'h00, 0, 0, 0,  ex(5,  10'b0010000000, 4'b0010, 0, 1, 1)); // sw
    run(6'h00, 6'h22, 0, 0, 0,  ex(4,  10'b1100000000, 4'b0110, 0, 0, 0)); // sub
    run(6'h00, 6'h24, 0, 0, 0,  ex(4,  10'b1100000000, 4'b0000, 0, 0, 0)); // and
    run(6'h00, 6'h25, 0, 0, 0,  ex(4,  10'b1100000000, 4'b0001, 0, 0, 0)); // or
    run(6'h00, 6'h2A, 0, 0, 0,  ex(4,  10'b1100000000, 4'b0111, 0, 0, 0)); // slt
    run(6'h00, 6'h00, 0, 0, 0,  ex(4,  10'b1100000010, 4'b1000, 0, 0, 0)); // sll
    run(6'h00, 6'h02, 0, 0, 0,  ex(4,  10'b1100000001, 4'b1001, 0, 0, 0)); // srl
    run(6'h00, 6'h08, 0, 0, 0,  ex(3,  10'b0100000100, 4'b0000, 1, 0, 0)); // jr
    run(6'h02, 6'h00, 0, 0, 0,  ex(3,  10'b0000010000, 4'b0000, 1, 0, 0)); // j
    run(6'h03, 6'h00, 0, 0, 0,  ex(3,  10'b1000011000, 4'b0000, 1, 0, 0)); // jal
    run(6'h08, 6'h00, 0, 2, 0,  ex(6,  10'b1010000000, 4'b0010, 0, 0, 0)); // addi, 2 fetch waits
    run(6'h23, 6'h00, 0, 0, 15, ex(20, 10'b1011000000, 4'b0010, 0, 16, 0)); // ready on limit
    chk("retired_total", retired, 17);

    // Reset during MEM of a stalled sw aborts it cleanly.
    opcode = 6'h2B; funct = 0; imem_lat = 0; dmem_lat = 1000;
    for (int i = 0; i < 20 && !dmem_req; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("sw_in_mem", dmem_req, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_no_pcw", pc_write, 0);
    @(negedge clk);
    chk("rst_mid_fetch", imem_req, 1);
    chk("rst_mid_dmem_req", dmem_req, 0);
    chk("rst_mid_pc_write", pc_write, 0);
    chk("rst_mid_retired", retired, 0);
    @(posedge clk); #1 rst = 0;
    exp_ret = 0;

    // Illegal opcode
    run(6'h3F, 6'h00, 0, 0, 0, tx(3));
    trap_hold_check();
    do_reset();
    // Illegal R-type funct
    run(6'h00, 6'h01, 0, 0, 0, tx(3));
    trap_hold_check();
    do_reset();
    // imem_ready stuck low: 16 FETCH cycles then TRAP
    run(6'h00, 6'h20, 0, 1000, 0, tx(17));
    trap_hold_check();
    do_reset();
    // dmem_ready one cycle too late
    run(6'h23, 6'h00, 0, 0, 16, tx(20));
    trap_hold_check();
    do_reset();
    run(6'h00, 6'h20, 0, 0, 0, ex(4, 10'b1100000000, 4'b0010, 0, 0, 0)); // recovers
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
